// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and receiver: oversampling,
// receiver FSM encoding and the baud divisor table (50 MHz clock).
package uart_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int CENTRE_TICK = OVERSAMPLE / 2 - 1;
    localparam int DIV_W       = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // clk cycles per sample_ENABLE tick, i.e. 50 MHz / (16 * baud)
    function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
        logic [DIV_W-1:0] div;
        case (sel)
            3'b000:  div = 14'd10417;
            3'b001:  div = 14'd2604;
            3'b010:  div = 14'd651;
            3'b011:  div = 14'd326;
            3'b100:  div = 14'd163;
            3'b101:  div = 14'd81;
            3'b110:  div = 14'd54;
            default: div = 14'd27;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Generates the 16x-oversampling tick (one clk wide) for the selected baud rate.
module baud_controller
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] limit;

    assign limit = baud_divisor(baud_select) - DIV_W'(1);

    // >= rather than == so a baud change to a shorter divisor cannot strand the counter
    assign sample_ENABLE = (cnt_q >= limit);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (sample_ENABLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled, centre-sampled 8E1 frames with parity
// and framing error reporting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    localparam int             TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  END_TICK = TW'(OVERSAMPLE - 1);

    logic                   sample_en;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_s;
    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   armed_q, armed_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   mid_tick, end_tick;

    baud_controller u_baud (
        .clk          (clk),
        .reset        (reset),
        .baud_select  (baud_select),
        .sample_ENABLE(sample_en)
    );

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], RxD};
    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign mid_tick = sample_en && (tick_q == MID_TICK);
    assign end_tick = sample_en && (tick_q == END_TICK);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        // A start needs a high line seen while idle; this holds off re-arming during a break.
        armed_d = rxd_s || (armed_q && state_q == IDLE);

        if (sample_en) begin
            tick_d = (tick_q == END_TICK) ? '0 : tick_q + TW'(1);
        end

        if (!Rx_EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s && armed_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (mid_tick) begin
                        if (!rxd_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (end_tick) begin
                        shift_d[bit_q] = rxd_s;
                        if (bit_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (end_tick) begin
                        par_d   = rxd_s;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (end_tick) begin
                        state_d = IDLE;
                        data_d  = shift_q;
                        perr_d  = (^shift_q) ^ par_q;
                        ferr_d  = ~rxd_s;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 115200 baud: frame table plus hand-written
// glitch, back-to-back, reset/enable abort and break sequences.
module tb_uart_receiver;

    localparam int CLKS_PER_BIT = 16 * 27;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'b111;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

    uart_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_BUSY    (Rx_BUSY)
    );

    always #10 clk = ~clk;

    int         n_vec = 0;
    int         n_miss = 0;
    int         valid_cycles = 0;
    int         busy_cycles = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic [1:0] last_err = 2'b00, prev_err = 2'b00;

    // Record every valid cycle and its payload as {PERROR, FERROR}
    always @(negedge clk) begin
        busy_cycles <= busy_cycles + (Rx_BUSY ? 1 : 0);
        if (Rx_VALID) begin
            valid_cycles <= valid_cycles + 1;
            prev_data    <= last_data;
            last_data    <= Rx_DATA;
            prev_err     <= last_err;
            last_err     <= {Rx_PERROR, Rx_FERROR};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_b, input int nbits);
        logic [10:0] f;
        f = {stop_b, (^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
    endtask

    task automatic idle_bits(input int n);
        RxD = 1'b1;
        repeat (n * CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par_flip;
        logic       stop_b;
        logic [7:0] exp_d;
        logic       exp_p;
        logic       exp_f;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int v0, b0;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[5] = '{8'h6E, 1'b1, 1'b0, 8'h6E, 1'b1, 1'b1};

        repeat (5) @(negedge clk);
        #1;
        check("rst_data",  32'(Rx_DATA),   32'h00);
        check("rst_valid", 32'(Rx_VALID),  32'h0);
        check("rst_perr",  32'(Rx_PERROR), 32'h0);
        check("rst_ferr",  32'(Rx_FERROR), 32'h0);
        check("rst_busy",  32'(Rx_BUSY),   32'h0);
        reset = 1'b1;
        Rx_EN = 1'b1;
        idle_bits(1);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cycles;
            b0 = busy_cycles;
            send_frame(tbl[i].d, tbl[i].par_flip, tbl[i].stop_b, 11);
            idle_bits(1);
            settle();
            check($sformatf("vec%0d_valid_cnt", i), 32'(valid_cycles - v0), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(last_data), 32'(tbl[i].exp_d));
            check($sformatf("vec%0d_perr", i), 32'(last_err[1]), 32'(tbl[i].exp_p));
            check($sformatf("vec%0d_ferr", i), 32'(last_err[0]), 32'(tbl[i].exp_f));
            check($sformatf("vec%0d_hold_data", i), 32'(Rx_DATA), 32'(tbl[i].exp_d));
            check($sformatf("vec%0d_busy_idle", i), 32'(Rx_BUSY), 32'h0);
            if (i == 0) begin
                // about 10.5 bit periods from start detection to stop centre
                check("busy_len", 32'((busy_cycles - b0 >= 4450) && (busy_cycles - b0 <= 4620)), 32'h1);
            end
        end

        // Short low glitch while idle
        v0 = valid_cycles;
        RxD = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_seen", 32'(Rx_BUSY), 32'h1);
        repeat (71) @(negedge clk);
        RxD = 1'b1;
        repeat (10 * 27) @(negedge clk);
        check("glitch_busy_clear", 32'(Rx_BUSY), 32'h0);
        idle_bits(1);
        settle();
        check("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_hold_data", 32'(Rx_DATA), 32'h6E);
        check("glitch_hold_perr", 32'(Rx_PERROR), 32'h1);
        check("glitch_hold_ferr", 32'(Rx_FERROR), 32'h1);

        // Back-to-back frames with no idle gap
        v0 = valid_cycles;
        send_frame(8'h3C, 1'b0, 1'b1, 11);
        send_frame(8'hC3, 1'b0, 1'b1, 11);
        idle_bits(1);
        settle();
        check("b2b_valid_cnt", 32'(valid_cycles - v0), 32'd2);
        check("b2b_first",     32'(prev_data), 32'h3C);
        check("b2b_second",    32'(last_data), 32'hC3);
        check("b2b_first_err", 32'(prev_err),  32'h0);
        check("b2b_second_err", 32'(last_err), 32'h0);

        // Reset during D4
        v0 = valid_cycles;
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        check("rstmid_busy_before", 32'(Rx_BUSY), 32'h1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_data", 32'(Rx_DATA),   32'h00);
        check("rstmid_busy", 32'(Rx_BUSY),   32'h0);
        check("rstmid_perr", 32'(Rx_PERROR), 32'h0);
        check("rstmid_ferr", 32'(Rx_FERROR), 32'h0);
        reset = 1'b1;
        idle_bits(2);
        settle();
        check("rstmid_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Rx_EN drop during D4
        v0 = valid_cycles;
        send_frame(8'h5A, 1'b0, 1'b1, 5);
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        check("en_busy_before", 32'(Rx_BUSY), 32'h1);
        Rx_EN = 1'b0;
        @(negedge clk);
        #1;
        check("en_busy_dropped", 32'(Rx_BUSY), 32'h0);
        idle_bits(7);
        Rx_EN = 1'b1;
        idle_bits(1);
        settle();
        check("en_no_valid",  32'(valid_cycles - v0), 32'd0);
        check("en_hold_data", 32'(Rx_DATA), 32'h00);

        // Break: line low for 13 bit periods, then recovery frame
        v0 = valid_cycles;
        RxD = 1'b0;
        repeat (13 * CLKS_PER_BIT) @(negedge clk);
        idle_bits(2);
        settle();
        check("break_valid_cnt", 32'(valid_cycles - v0), 32'd1);
        check("break_data",      32'(last_data), 32'h00);
        check("break_err",       32'(last_err),  32'h1);
        check("break_ferr_hold", 32'(Rx_FERROR), 32'h1);
        v0 = valid_cycles;
        send_frame(8'h96, 1'b0, 1'b1, 11);
        idle_bits(1);
        settle();
        check("recover_valid_cnt", 32'(valid_cycles - v0), 32'd1);
        check("recover_data",      32'(last_data), 32'h96);
        check("recover_err",       32'(last_err),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
